// File: rtl/card_rng_pkg.sv
// rtl/card_rng_pkg.sv - shared types, mode constants and LFSR tap table for card_rng
package card_rng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } draw_state_t;

    localparam int MODE_COUNTER = 0;
    localparam int MODE_LFSR    = 1;

    // Right-shift Galois masks: term x^k of the primitive polynomial sets bit k-1.
    function automatic logic [15:0] tap_mask(input int width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/card_rng_core.sv
// rtl/card_rng_core.sv - free-running generator register (rng_core): counter or Galois LFSR
module rng_core
    import card_rng_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int MODE  = MODE_LFSR,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] raw
);

    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(tap_mask(WIDTH));

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] advance;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        if (MODE == MODE_LFSR) begin
            advance = (state >> 1) ^ (state[0] ? TAPS : '0);
        end else begin
            advance = state + WIDTH'(1);
        end
        // An all-zero LFSR would lock up, so a zero seed falls back to SEED.
        load_val = seed_in;
        if (MODE == MODE_LFSR && seed_in == '0) begin
            load_val = SEED_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED_W;
        end else if (seed_load) begin
            state <= load_val;
        end else begin
            state <= advance;
        end
    end

    assign raw = state;

endmodule

// File: rtl/card_rng.sv
// rtl/card_rng.sv - draw FSM issuing cards 1..LIMIT by rejection sampling the generator
module card_rng
    import card_rng_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int MODE  = MODE_LFSR,
    parameter int LIMIT = 52,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             card_valid,
    output logic [WIDTH-1:0] card,
    input  logic             card_ready,
    output logic [WIDTH-1:0] raw
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    draw_state_t      state;
    draw_state_t      next_state;
    logic [WIDTH-1:0] card_next;

    rng_core #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .raw       (raw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            card  <= '0;
        end else begin
            state <= next_state;
            card  <= card_next;
        end
    end

    always_comb begin
        next_state = state;
        card_next  = card;
        req_ready  = 1'b0;
        card_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = SAMPLE;
            end
            SAMPLE: begin
                // Out-of-range values are rejected; the generator moves on every cycle.
                if (raw != '0 && raw <= LIMIT_W) begin
                    card_next  = raw;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                card_valid = 1'b1;
                if (card_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_card_rng.sv
// tb/tb_card_rng.sv - self-checking bench for card_rng (counter and LFSR instances)
module tb_card_rng;

    localparam int W   = 6;
    localparam int LIM = 52;
    localparam int SD  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         c_reset, c_seed_load, c_req_valid, c_card_ready;
    logic [W-1:0] c_seed_in;
    logic         c_req_ready, c_card_valid;
    logic [W-1:0] c_card, c_raw;

    logic         l_reset, l_seed_load, l_req_valid, l_card_ready;
    logic [W-1:0] l_seed_in;
    logic         l_req_ready, l_card_valid;
    logic [W-1:0] l_card, l_raw;

    int errors = 0;
    int checks = 0;

    card_rng #(.WIDTH(W), .MODE(0), .LIMIT(LIM), .SEED(SD)) u_cnt (
        .clk        (clk),
        .reset      (c_reset),
        .seed_load  (c_seed_load),
        .seed_in    (c_seed_in),
        .req_valid  (c_req_valid),
        .req_ready  (c_req_ready),
        .card_valid (c_card_valid),
        .card       (c_card),
        .card_ready (c_card_ready),
        .raw        (c_raw)
    );

    card_rng #(.WIDTH(W), .MODE(1), .LIMIT(LIM), .SEED(SD)) u_lfsr (
        .clk        (clk),
        .reset      (l_reset),
        .seed_load  (l_seed_load),
        .seed_in    (l_seed_in),
        .req_valid  (l_req_valid),
        .req_ready  (l_req_ready),
        .card_valid (l_card_valid),
        .card       (l_card),
        .card_ready (l_card_ready),
        .raw        (l_raw)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_cnt(input int unsigned v);
        c_seed_load = 1'b1;
        c_seed_in   = W'(v);
        step();
        c_seed_load = 1'b0;
    endtask

    // Reference model state for the randomized phase
    int unsigned m_raw, m_phase, m_card;
    bit          seen [64];
    int          n;

    initial begin
        c_reset = 1'b1; c_seed_load = 1'b0; c_seed_in = '0; c_req_valid = 1'b0; c_card_ready = 1'b0;
        l_reset = 1'b1; l_seed_load = 1'b0; l_seed_in = '0; l_req_valid = 1'b0; l_card_ready = 1'b0;
        #1;
        step();
        c_reset = 1'b0;
        l_reset = 1'b0;

        check_eq("reset_raw",        c_raw, SD);
        check_eq("reset_req_ready",  c_req_ready, 1);
        check_eq("reset_card_valid", c_card_valid, 0);
        check_eq("reset_card",       c_card, 0);

        // Counter wraps after 64 cycles
        for (int i = 1; i <= 64; i++) begin
            step();
            check_eq("count_raw", c_raw, (1 + i) % 64);
        end

        // Seed 10, request next cycle: first sample sees 11
        seed_cnt(10);
        check_eq("seed_raw", c_raw, 10);
        c_req_valid = 1'b1;
        step();
        c_req_valid = 1'b0;
        check_eq("sample_req_ready",  c_req_ready, 0);
        check_eq("sample_card_valid", c_card_valid, 0);
        step();
        check_eq("hold_card_valid", c_card_valid, 1);
        check_eq("hold_card",       c_card, 11);
        c_card_ready = 1'b1;
        step();
        c_card_ready = 1'b0;
        check_eq("release_req_ready", c_req_ready, 1);

        // Seed 52: 53..63 and 0 rejected, card 1 after 14 edges
        seed_cnt(52);
        c_req_valid = 1'b1;
        step();
        c_req_valid = 1'b0;
        n = 1;
        while (!c_card_valid && n < 70) begin
            step();
            n++;
        end
        check_eq("reject_latency", n, 14);
        check_eq("reject_card",    c_card, 1);

        // HOLD is stable for 10 cycles and ignores req_valid
        c_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("stall_card",       c_card, 1);
            check_eq("stall_card_valid", c_card_valid, 1);
            check_eq("stall_req_ready",  c_req_ready, 0);
        end
        c_req_valid  = 1'b0;
        c_card_ready = 1'b1;
        step();
        c_card_ready = 1'b0;
        check_eq("stall_release_ready", c_req_ready, 1);
        check_eq("stall_release_valid", c_card_valid, 0);
        step();
        check_eq("no_queued_request", c_req_ready, 1);

        // Reset during SAMPLE, overriding a concurrent seed_load
        seed_cnt(52);
        c_req_valid = 1'b1;
        step();
        c_req_valid = 1'b0;
        c_reset = 1'b1; c_seed_load = 1'b1; c_seed_in = 6'd20;
        step();
        c_reset = 1'b0; c_seed_load = 1'b0;
        check_eq("rst_sample_valid", c_card_valid, 0);
        check_eq("rst_sample_card",  c_card, 0);
        check_eq("rst_sample_raw",   c_raw, SD);
        check_eq("rst_sample_ready", c_req_ready, 1);
        for (int i = 0; i < 15; i++) begin
            step();
            check_eq("rst_sample_no_card", c_card_valid, 0);
        end

        // Reset during HOLD
        seed_cnt(10);
        c_req_valid = 1'b1;
        step();
        c_req_valid = 1'b0;
        step();
        check_eq("pre_rst_hold_valid", c_card_valid, 1);
        c_reset = 1'b1;
        step();
        c_reset = 1'b0;
        check_eq("rst_hold_valid", c_card_valid, 0);
        check_eq("rst_hold_card",  c_card, 0);
        check_eq("rst_hold_raw",   c_raw, SD);
        check_eq("rst_hold_ready", c_req_ready, 1);

        // Randomized traffic against a behavioural model of the counter instance
        c_reset = 1'b1;
        step();
        m_raw = SD; m_phase = 0; m_card = 0;
        for (int i = 0; i < 400; i++) begin
            check_eq("rnd_raw",        c_raw, m_raw);
            check_eq("rnd_req_ready",  c_req_ready, m_phase == 0);
            check_eq("rnd_card_valid", c_card_valid, m_phase == 2);
            check_eq("rnd_card",       c_card, m_card);
            c_reset      = ($urandom_range(0, 39) == 0);
            c_seed_load  = ($urandom_range(0, 9) == 0);
            c_seed_in    = W'($urandom_range(0, 63));
            c_req_valid  = $urandom_range(0, 1) == 1;
            c_card_ready = ($urandom_range(0, 2) == 0);
            if (c_reset) begin
                m_raw = SD; m_phase = 0; m_card = 0;
            end else begin
                if (m_phase == 0) begin
                    if (c_req_valid) m_phase = 1;
                end else if (m_phase == 1) begin
                    if (m_raw >= 1 && m_raw <= LIM) begin
                        m_card  = m_raw;
                        m_phase = 2;
                    end
                end else if (c_card_ready) begin
                    m_phase = 0;
                end
                m_raw = c_seed_load ? int'(c_seed_in) : (m_raw + 1) % 64;
            end
            step();
        end
        c_reset = 1'b0; c_seed_load = 1'b0; c_req_valid = 1'b0; c_card_ready = 1'b0;

        // LFSR: full period of 63 distinct nonzero states, back to SEED
        l_reset = 1'b1;
        step();
        l_reset = 1'b0;
        check_eq("lfsr_reset_raw", l_raw, SD);
        foreach (seen[k]) seen[k] = 1'b0;
        seen[SD] = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            step();
            if (i < 63) begin
                check_eq("lfsr_nonzero", l_raw == 0, 0);
                check_eq("lfsr_repeat",  seen[l_raw], 0);
                seen[l_raw] = 1'b1;
            end else begin
                check_eq("lfsr_period", l_raw, SD);
            end
        end
        l_seed_load = 1'b1; l_seed_in = '0;
        step();
        check_eq("lfsr_zero_seed", l_raw, SD);
        l_seed_in = 6'd37;
        step();
        l_seed_load = 1'b0;
        check_eq("lfsr_seed", l_raw, 37);

        l_req_valid = 1'b1;
        step();
        l_req_valid = 1'b0;
        n = 1;
        while (!l_card_valid && n < 70) begin
            step();
            n++;
        end
        check_eq("lfsr_card_valid", l_card_valid, 1);
        check_eq("lfsr_card_range", (l_card >= 1) && (l_card <= LIM), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_rng.md
CARD_RNG -- requirements
Module: card_rng

Interface
REQ-001 Parameter WIDTH, default 6, state/card width; legal range 3..16.
REQ-002 Parameter MODE, default 1, generator mode: 0 = wrapping up-counter, 1 = maximal-length Galois LFSR.
REQ-003 Parameter LIMIT, default 52, largest card value issued; legal range 1..2^WIDTH-1.
REQ-004 Parameter SEED, default 1, reset/substitute state; SHALL be nonzero.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 seed_load  in  1  load seed_in into generator state this cycle.
REQ-008 seed_in  in  WIDTH  seed value.
REQ-009 req_valid  in  1  draw request.
REQ-010 req_ready  out  1  module can accept a draw request.
REQ-011 card_valid  out  1  card holds a drawn value.
REQ-012 card  out  WIDTH  drawn value, 1..LIMIT when card_valid.
REQ-013 card_ready  in  1  consumer takes the card.
REQ-014 raw  out  WIDTH  current generator state, registered.

Function
REQ-015 Generator SHALL advance every cycle when reset and seed_load are low (free-running, no enable).
REQ-016 MODE 0: next = state + 1 modulo 2^WIDTH; 2^WIDTH-1 wraps to 0.
REQ-017 MODE 1: Galois right-shift, XOR tap mask from package when shifted-out bit is 1; period 2^WIDTH-1; state never 0.
REQ-018 seed_load high: next state = seed_in; MODE 1 with seed_in = 0 SHALL load SEED instead; seed_load overrides advance.
REQ-019 Draw FSM states IDLE, SAMPLE, HOLD; req_ready = 1 only in IDLE; card_valid = 1 only in HOLD.
REQ-020 IDLE: req_valid = 1 -> SAMPLE next cycle; otherwise stay.
REQ-021 SAMPLE: if 1 <= raw <= LIMIT, capture card = raw and go HOLD; else stay (rejection); raw evaluated as registered, regardless of concurrent seed_load.
REQ-022 Latency: request accepted at cycle N -> first sample at N+1 -> earliest card_valid at N+2; worst case bounded by 2^WIDTH samples.
REQ-023 HOLD: card stable until card_ready = 1, then IDLE next cycle; req_valid in HOLD is ignored (not queued).
REQ-024 card_ready while not in HOLD SHALL have no effect.
REQ-025 raw SHALL equal the generator register with zero combinational path from inputs.

Reset
REQ-026 reset = 1: state <= SEED, FSM <= IDLE, card <= 0, card_valid <= 0, req_ready <= 1 after the edge.
REQ-027 reset SHALL override seed_load and abort any draw in SAMPLE or HOLD with no card delivered.

Structure
REQ-028 Package card_rng_pkg SHALL hold the FSM state enum, MODE constants, and a function returning the maximal-length tap mask per WIDTH 3..16 (WIDTH 6: x^6+x^5+1).
REQ-029 Generator register and next-state logic SHALL be sub-module rng_core (params WIDTH, MODE, SEED); draw FSM lives in card_rng.

Verification
REQ-030 MODE 0, WIDTH 6: release reset -> raw = 1, then 2, 3, ... 63, 0, 1; wraps after 64 cycles.
REQ-031 MODE 0, LIMIT 52: seed_load seed_in = 10, req_valid next cycle -> sample sees 11 -> card = 11, card_valid two cycles after request accepted.
REQ-032 MODE 0, LIMIT 52: seed_in = 52, req_valid next cycle -> samples 53..63, 0 rejected (12 cycles) -> card = 1.
REQ-033 MODE 1, WIDTH 6: run 63 cycles from SEED -> all 63 nonzero values visited once, state returns to SEED; seed_load with seed_in = 0 -> raw = SEED.
REQ-034 HOLD with card_ready low 10 cycles -> card/card_valid stable, req_valid ignored; card_ready = 1 -> IDLE, req_ready = 1 next cycle.
REQ-035 reset asserted in SAMPLE and again in HOLD -> card_valid = 0, card = 0, raw = SEED, FSM IDLE next cycle.
